// File: rtl/pwm_bank.sv
// pwm_bank: CHANNELS edge-aligned PWM outputs sharing one period counter, with
// per-channel debounced inc/dec buttons, direct duty load and double-buffered duties
// (pending target copied to active at each period start, so outputs never glitch).
// Optional feature macro: PWM_BANK_CENTER_ALIGN_EN adds a center-aligned (triangle) mode.
// Ports: clk/rst (sync, active-high); inc/dec raw buttons; load_en/load_ch/load_duty
// direct write; center mode select; rd_ch/rd_duty pending-duty readback (comb);
// pwm registered outputs; period_start registered pulse aligned with count 0.
module pwm_bank #(
    parameter int CHANNELS  = 4,
    parameter int CNT_W     = 8,
    parameter int PERIOD    = 10,
    parameter int DUTY_INIT = 5,
    parameter int STEP      = 1,
    parameter int DEB_DIV   = 2,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] inc,
    input  logic [CHANNELS-1:0] dec,
    input  logic                load_en,
    input  logic [CH_W-1:0]     load_ch,
    input  logic [CNT_W-1:0]    load_duty,
    input  logic                center,
    input  logic [CH_W-1:0]     rd_ch,
    output logic [CNT_W-1:0]    rd_duty,
    output logic [CHANNELS-1:0] pwm,
    output logic                period_start
);

    localparam int DIV_W = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
    localparam logic [CNT_W-1:0] PER   = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] INIT  = CNT_W'(DUTY_INIT);
    localparam logic [CNT_W-1:0] STP   = CNT_W'(STEP);
    localparam logic [CNT_W:0]   PER_X = (CNT_W+1)'(PERIOD);
    localparam logic [CNT_W:0]   STP_X = (CNT_W+1)'(STEP);

    // Debounce sample tick
    logic [DIV_W-1:0] div;
    logic             tick;
    assign tick = (div == DIV_W'(DEB_DIV - 1));

    logic [CHANNELS-1:0] inc_s1, inc_s2, dec_s1, dec_s2;
    logic [CHANNELS-1:0] inc_ev, dec_ev;
    assign inc_ev = inc_s1 & ~inc_s2 & {CHANNELS{tick}};
    assign dec_ev = dec_s1 & ~dec_s2 & {CHANNELS{tick}};

    logic [CHANNELS-1:0][CNT_W-1:0] target, target_nxt, active, act_sel;
    logic [CNT_W-1:0]               cnt, cnt_nxt;
    logic [CHANNELS-1:0]            pwm_nxt;
    logic                           ps_cond;

    // Pending duty update; saturation is evaluated one bit wider than the duty
    always_comb begin
        target_nxt = target;
        for (int i = 0; i < CHANNELS; i++) begin
            if (load_en && (int'(load_ch) == i)) begin
                target_nxt[i] = ({1'b0, load_duty} > PER_X) ? PER : load_duty;
            end else if (inc_ev[i] && dec_ev[i]) begin
                target_nxt[i] = target[i];
            end else if (inc_ev[i]) begin
                target_nxt[i] = (({1'b0, target[i]} + STP_X) > PER_X) ? PER : (target[i] + STP);
            end else if (dec_ev[i]) begin
                target_nxt[i] = ({1'b0, target[i]} >= STP_X) ? (target[i] - STP) : '0;
            end
        end
    end

    // The pwm sample taken at a period start already uses the freshly loaded duty
    assign act_sel = ps_cond ? target : active;

`ifdef PWM_BANK_CENTER_ALIGN_EN
    logic dir_dn, dir_nxt, mode_r, mode_eff;

    assign ps_cond  = (cnt == '0) && !dir_dn;
    // Mode is latched at the period start so a change never splits a period
    assign mode_eff = ps_cond ? center : mode_r;

    always_comb begin
        cnt_nxt = cnt;
        dir_nxt = 1'b0;
        if (mode_eff) begin
            dir_nxt = dir_dn;
            // Turnaround points repeat the end value once: 0..P-1, P-1..0
            if (!dir_dn) begin
                if (cnt == LAST) dir_nxt = 1'b1;
                else             cnt_nxt = cnt + CNT_W'(1);
            end else begin
                if (cnt == '0)   dir_nxt = 1'b0;
                else             cnt_nxt = cnt - CNT_W'(1);
            end
        end else begin
            cnt_nxt = (cnt == LAST) ? '0 : (cnt + CNT_W'(1));
        end
    end

    always_comb begin
        pwm_nxt = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            pwm_nxt[i] = mode_eff ? (cnt >= (PER - act_sel[i])) : (cnt < act_sel[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dir_dn <= 1'b0;
            mode_r <= 1'b0;
        end else begin
            dir_dn <= dir_nxt;
            mode_r <= mode_eff;
        end
    end
`else
    logic unused_center;
    assign unused_center = center;
    assign ps_cond       = (cnt == '0);

    always_comb begin
        cnt_nxt = (cnt == LAST) ? '0 : (cnt + CNT_W'(1));
    end

    always_comb begin
        pwm_nxt = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            pwm_nxt[i] = (cnt < act_sel[i]);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            div          <= '0;
            inc_s1       <= '0;
            inc_s2       <= '0;
            dec_s1       <= '0;
            dec_s2       <= '0;
            cnt          <= '0;
            pwm          <= '0;
            period_start <= 1'b0;
            target       <= {CHANNELS{INIT}};
            active       <= {CHANNELS{INIT}};
        end else begin
            div          <= tick ? '0 : (div + DIV_W'(1));
            if (tick) begin
                inc_s1 <= inc;
                inc_s2 <= inc_s1;
                dec_s1 <= dec;
                dec_s2 <= dec_s1;
            end
            cnt          <= cnt_nxt;
            pwm          <= pwm_nxt;
            period_start <= ps_cond;
            target       <= target_nxt;
            if (ps_cond) active <= target;
        end
    end

    always_comb begin
        rd_duty = '0;
        if (int'(rd_ch) < CHANNELS) rd_duty = target[rd_ch];
    end

endmodule

// File: tb/tb_pwm_bank.sv
// tb_pwm_bank: directed + random stimulus for pwm_bank with a scoreboard.
// A period/phase reference model predicts pwm, period_start and pending duties each clock;
// a monitor on the falling edge pops the prediction and compares against the DUT.
module tb_pwm_bank;

    localparam int CH = 2;
    localparam int CW = 4;
    localparam int P  = 10;
    localparam int DI = 5;
    localparam int ST = 1;
    localparam int DD = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CH-1:0] inc = '0;
    logic [CH-1:0] dec = '0;
    logic          load_en = 1'b0;
    logic [0:0]    load_ch = '0;
    logic [CW-1:0] load_duty = '0;
    logic          center = 1'b0;
    logic [0:0]    rd_ch = '0;
    logic [CW-1:0] rd_duty;
    logic [CH-1:0] pwm;
    logic          period_start;

    always #5 clk = ~clk;

    pwm_bank #(
        .CHANNELS(CH), .CNT_W(CW), .PERIOD(P), .DUTY_INIT(DI), .STEP(ST), .DEB_DIV(DD)
    ) dut (
        .clk(clk), .rst(rst), .inc(inc), .dec(dec),
        .load_en(load_en), .load_ch(load_ch), .load_duty(load_duty),
        .center(center), .rd_ch(rd_ch), .rd_duty(rd_duty),
        .pwm(pwm), .period_start(period_start)
    );

    typedef struct packed {
        logic [CH-1:0]         pwm;
        logic                  ps;
        logic [CH-1:0][CW-1:0] tgt;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state: position inside the current period, not a counter copy
    int phase, mode, tcount, plen, tri_val;
    int tgt[CH];
    int act[CH];
    bit inc_last[CH], inc_prev[CH], dec_last[CH], dec_prev[CH];
    bit tick_now, iev, dev;
    exp_t e_m;

    always @(posedge clk) begin
        e_m = '0;
        if (rst) begin
            phase  = 0;
            mode   = 0;
            tcount = 0;
            for (int c = 0; c < CH; c++) begin
                tgt[c] = DI; act[c] = DI;
                inc_last[c] = 0; inc_prev[c] = 0; dec_last[c] = 0; dec_prev[c] = 0;
            end
        end else begin
            tick_now = ((tcount % DD) == DD - 1);
            tcount++;
            if (phase == 0) begin
`ifdef PWM_BANK_CENTER_ALIGN_EN
                mode = int'(center);
`endif
                for (int c = 0; c < CH; c++) act[c] = tgt[c];
            end
            e_m.ps = (phase == 0);
            tri_val = (phase < P) ? phase : (2 * P - 1 - phase);
            for (int c = 0; c < CH; c++) begin
                if (mode != 0) e_m.pwm[c] = (tri_val >= P - act[c]);
                else           e_m.pwm[c] = (phase < act[c]);
            end
            plen  = (mode != 0) ? 2 * P : P;
            phase = (phase + 1) % plen;
            for (int c = 0; c < CH; c++) begin
                // A press is the rising edge of the tick-sampled button stream
                iev = tick_now && inc_last[c] && !inc_prev[c];
                dev = tick_now && dec_last[c] && !dec_prev[c];
                if (tick_now) begin
                    inc_prev[c] = inc_last[c]; inc_last[c] = inc[c];
                    dec_prev[c] = dec_last[c]; dec_last[c] = dec[c];
                end
                if (load_en && int'(load_ch) == c) tgt[c] = (int'(load_duty) > P) ? P : int'(load_duty);
                else if (iev && dev)               tgt[c] = tgt[c];
                else if (iev)                      tgt[c] = (tgt[c] + ST > P) ? P : tgt[c] + ST;
                else if (dev)                      tgt[c] = (tgt[c] >= ST) ? tgt[c] - ST : 0;
            end
        end
        for (int c = 0; c < CH; c++) e_m.tgt[c] = CW'(tgt[c]);
        q.push_back(e_m);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, want);
        end
    endtask

    exp_t e_c;
    always @(negedge clk) begin
        if (q.size() > 0) begin
            e_c = q.pop_front();
            chk("pwm", 32'(pwm), 32'(e_c.pwm));
            chk("period_start", 32'(period_start), 32'(e_c.ps));
            chk("rd_duty", 32'(rd_duty), 32'(e_c.tgt[rd_ch]));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic load(input int ch, input int duty);
        load_en   = 1'b1;
        load_ch   = 1'(ch);
        load_duty = CW'(duty);
        step(1);
        load_en   = 1'b0;
    endtask

    initial begin
        step(3);
        rst = 1'b0;
        step(30);

        // Held inc steps exactly once
        rd_ch  = 1'b0;
        inc[0] = 1'b1;
        step(40);
        inc[0] = 1'b0;
        step(25);

        // dec saturates at 0, then over-range load clamps to PERIOD
        rd_ch = 1'b1;
        repeat (8) begin
            dec[1] = 1'b1; step(4);
            dec[1] = 1'b0; step(4);
        end
        step(20);
        load(1, 15);
        step(25);

        // load_en swept across the inc event cycle
        rd_ch = 1'b0;
        for (int k = 0; k < 6; k++) begin
            load(0, 7);
            step(4);
            inc[0] = 1'b1;
            step(k);
            load(0, 2);
            step(6 - k);
            inc[0] = 1'b0;
            step(6);
        end

        // Mid-period reset with a non-default duty
        load(0, 8);
        step(P + 7);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(25);

        // Random mix; center toggles too (ignored in the edge-only build)
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 5) == 0) inc[0] = ~inc[0];
            if ($urandom_range(0, 5) == 0) inc[1] = ~inc[1];
            if ($urandom_range(0, 5) == 0) dec[0] = ~dec[0];
            if ($urandom_range(0, 5) == 0) dec[1] = ~dec[1];
            load_en   = ($urandom_range(0, 19) == 0);
            load_ch   = 1'($urandom_range(0, 1));
            load_duty = CW'($urandom_range(0, 15));
            rd_ch     = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 49) == 0) center = ~center;
            rst       = ($urandom_range(0, 199) == 0);
            step(1);
        end
        inc = '0; dec = '0; load_en = 1'b0; rst = 1'b0; center = 1'b0;
        step(30);

`ifdef PWM_BANK_CENTER_ALIGN_EN
        center = 1'b1;
        load(0, 3);
        load(1, 10);
        step(70);
        load(1, 0);
        step(50);
        center = 1'b0;
        step(30);
`endif

        step(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
